reg_op_sequencer: RTL and testbench

- Initiator-side controller for the 16x32 general register file. It drives the register file's read-address, write-address, write-data and write-enable pins.
- Accepts one register-to-register command at a time over a valid/ready handshake. For each command it reads operands, computes the result and writes it back.
- Returns a response with the result and an error flag, and sits between the host/test controller and the register file.
- Register address 15 is reserved; the sequencer never issues a write to it.

---
 rtl/reg_op_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Register-file command sequencer: accepts one register-to-register command,
// reads operands, computes the result, writes it back and returns a response.
module reg_op_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RSV_ADDR = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              rf_write,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_zero,
  output logic [15:0]       wr_count
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_RD  = 3'b111;

  localparam logic [ADDR_W-1:0] RSV = ADDR_W'(RSV_ADDR);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic              cmd_ready_d;
  logic [ADDR_W-1:0] addr_a_d, addr_b_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_data_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_err_d;
  logic              rsp_zero_d;
  logic [CNT_W-1:0]  wr_count_d;

  logic [DATA_W-1:0] alu_c;
  logic              err_c;

  // Result of the latched operation on the captured operands
  always_comb begin
    alu_c = '0;
    unique case (op_q)
      OP_MOV:  alu_c = opa_q;
      OP_ADD:  alu_c = DATA_W'(opa_q + opb_q);
      OP_SUB:  alu_c = DATA_W'(opa_q - opb_q);
      OP_AND:  alu_c = opa_q & opb_q;
      OP_OR:   alu_c = opa_q | opb_q;
      OP_XOR:  alu_c = opa_q ^ opb_q;
      OP_LDI:  alu_c = imm_q;
      OP_RD:   alu_c = opa_q;
      default: alu_c = '0;
    endcase
    err_c = (op_q != OP_RD) && (rd_q == RSV);
  end

  // Next-state and next-output logic for the command sequence
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    err_d       = err_q;
    write_d     = 1'b0;
    addr_a_d    = rf_addr_a;
    addr_b_d    = rf_addr_b;
    w_addr_d    = rf_w_addr;
    w_data_d    = rf_w_data;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    rsp_zero_d  = rsp_zero;
    wr_count_d  = wr_count;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d     = cmd_op;
          rd_d     = cmd_rd;
          imm_d    = cmd_imm;
          addr_a_d = cmd_rs1;
          addr_b_d = cmd_rs2;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        opa_d   = rf_data_a;
        opb_d   = rf_data_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_c;
        err_d    = err_c;
        write_d  = (op_q != OP_RD) && !err_c;
        w_addr_d = rd_q;
        w_data_d = alu_c;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (write_q && (wr_count != CNT_MAX)) begin
          wr_count_d = CNT_W'(wr_count + CNT_W'(1));
        end
        rsp_valid_d = 1'b1;
        rsp_data_d  = result_q;
        rsp_err_d   = err_q;
        rsp_zero_d  = (result_q == '0);
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      cmd_ready <= 1'b1;
      rf_addr_a <= '0;
      rf_addr_b <= '0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_zero  <= 1'b0;
      wr_count  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      err_q     <= err_d;
      write_q   <= write_d;
      cmd_ready <= cmd_ready_d;
      rf_addr_a <= addr_a_d;
      rf_addr_b <= addr_b_d;
      rf_w_addr <= w_addr_d;
      rf_w_data <= w_data_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      rsp_zero  <= rsp_zero_d;
      wr_count  <= wr_count_d;
    end
  end

  // Write strobe is cut immediately by reset so an interrupted WRITE never lands
  assign rf_write = write_q && !rst;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a register-file model and a
// response scoreboard.
module tb_reg_op_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [DW-1:0] cmd_imm;
  logic [AW-1:0] rf_addr_a;
  logic [AW-1:0] rf_addr_b;
  logic [DW-1:0] rf_data_a;
  logic [DW-1:0] rf_data_b;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic          rf_write;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_zero;
  logic [15:0]   wr_count;

  reg_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .rf_addr_a (rf_addr_a),
    .rf_addr_b (rf_addr_b),
    .rf_data_a (rf_data_a),
    .rf_data_b (rf_data_b),
    .rf_w_addr (rf_w_addr),
    .rf_w_data (rf_w_data),
    .rf_write  (rf_write),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_zero  (rsp_zero),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: combinational reads, falling-edge writes
  logic [DW-1:0] regs [16] = '{default: '0};
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  int            wcount = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  // Apply DUT writes (or bench preloads) and log each write pulse
  always @(negedge clk) begin
    if (rf_write) begin
      regs[rf_w_addr] <= rf_w_data;
      wcount          <= wcount + 1;
      last_waddr      <= rf_w_addr;
      last_wdata      <= rf_w_data;
    end else if (pl_en) begin
      regs[pl_addr] <= pl_data;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] shadow [16];
  logic [33:0]   rsp_q [$];
  int            exp_wc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] imm);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return imm;
      default: return a;
    endcase
  endfunction

  // Preload one register in both the model and the shadow copy (call at negedge)
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    shadow[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive a command at a negedge; returns once it has been accepted (or timed out)
  task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input logic [DW-1:0] imm, output bit accepted);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    accepted  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cmd_accept", 64'(accepted), 64'd1);
  endtask

  // Full command: scoreboard push, handshake, latency, response, write and counter checks
  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [DW-1:0] imm, input bit hold);
    logic [DW-1:0] res;
    logic [DW-1:0] held;
    logic [33:0]   exp;
    bit            err, wr, accepted, got;
    int            w0, edges;
    res = model(op, shadow[rs1], shadow[rs2], imm);
    err = (op != 3'd7) && (rd == 4'd15);
    wr  = (op != 3'd7) && !err;
    rsp_q.push_back({res, err, (res == '0)});
    w0 = wcount;
    if (hold) rsp_ready = 1'b0;
    send(op, rd, rs1, rs2, imm, accepted);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_imm   = '0;
    edges = 0;
    got   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
    check("rsp_seen", 64'(got), 64'd1);
    check("rsp_latency", 64'(edges), 64'd3);
    if (hold) begin
      held      = rsp_data;
      cmd_valid = 1'b1;
      cmd_op    = 3'd6;
      cmd_rd    = 4'd11;
      cmd_imm   = 32'hDEAD_BEEF;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_data", 64'(rsp_data), 64'(held));
        check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    exp = rsp_q.pop_front();
    check("rsp_data", 64'(rsp_data), 64'(exp[33:2]));
    check("rsp_err", 64'(rsp_err), 64'(exp[1]));
    check("rsp_zero", 64'(rsp_zero), 64'(exp[0]));
    @(negedge clk);
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    check("idle_ready", 64'(cmd_ready), 64'd1);
    if (wr) begin
      shadow[rd] = res;
      exp_wc++;
    end
    check("write_pulses", 64'(wcount - w0), 64'(wr));
    if (wr) begin
      check("write_addr", 64'(last_waddr), 64'(rd));
      check("write_data", 64'(last_wdata), 64'(res));
    end
    check("wr_count", 64'(wr_count), 64'(exp_wc));
    check("rf_dest", 64'(regs[rd]), 64'(shadow[rd]));
    check("rf_r15", 64'(regs[15]), 64'(shadow[15]));
  endtask

  initial begin
    bit accepted;
    int w0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_imm   = '0;
    rsp_ready = 1'b1;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rf_write", 64'(rf_write), 64'd0);
    check("rst_addr_a", 64'(rf_addr_a), 64'd0);
    check("rst_w_addr", 64'(rf_w_addr), 64'd0);
    check("rst_w_data", 64'(rf_w_data), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    rst = 1'b0;

    run_cmd(3'd6, 4'd3, 4'd0, 4'd0, 32'h0000_00A5, 1'b0);
    preload(4'd1, 32'hFFFF_FFFF);
    preload(4'd2, 32'h0000_0001);
    run_cmd(3'd1, 4'd4, 4'd1, 4'd2, '0, 1'b0);
    run_cmd(3'd2, 4'd5, 4'd2, 4'd1, '0, 1'b0);
    run_cmd(3'd5, 4'd2, 4'd2, 4'd2, '0, 1'b0);
    run_cmd(3'd6, 4'd15, 4'd0, 4'd0, 32'h0000_0007, 1'b0);
    run_cmd(3'd7, 4'd15, 4'd3, 4'd0, '0, 1'b0);
    run_cmd(3'd0, 4'd7, 4'd3, 4'd0, '0, 1'b0);
    run_cmd(3'd3, 4'd8, 4'd1, 4'd3, '0, 1'b0);
    run_cmd(3'd4, 4'd9, 4'd5, 4'd3, '0, 1'b0);
    run_cmd(3'd1, 4'd10, 4'd3, 4'd5, '0, 1'b1);

    // Reset lands in the middle of the WRITE cycle of ADD rd=6
    w0 = wcount;
    send(3'd1, 4'd6, 4'd3, 4'd3, '0, accepted);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midrst_rf_write", 64'(rf_write), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_wc = 0;
    check("midrst_pulses", 64'(wcount - w0), 64'd0);
    check("midrst_r6", 64'(regs[6]), 64'(shadow[6]));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_wr_count", 64'(wr_count), 64'd0);

    run_cmd(3'd6, 4'd12, 4'd0, 4'd0, 32'h1234_5678, 1'b0);
    check("scoreboard_empty", 64'(rsp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
